// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC core: ISA opcodes, controller
// state encodings and the bit layout of the controller's control vector.
package cpu_pkg;

    // Opcode field width of the 3-bit ISA.
    localparam int OPC_W = 3;

    // Opcodes, shared with the ALU.
    localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OP_AND = 3'd3;
    localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPC_W-1:0] OP_STO = 3'd6;
    localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

    // Controller states. S0..S7 are the eight steps of one instruction.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        S0   = 4'd1,
        S1   = 4'd2,
        S2   = 4'd3,
        S3   = 4'd4,
        S4   = 4'd5,
        S5   = 4'd6,
        S6   = 4'd7,
        S7   = 4'd8,
        HALT = 4'd9
    } state_t;

    // Control-vector field order (bit index of each strobe).
    localparam int CTL_W           = 9;
    localparam int CTL_LOAD_IR     = 0;
    localparam int CTL_RD          = 1;
    localparam int CTL_WR          = 2;
    localparam int CTL_INC_PC      = 3;
    localparam int CTL_LOAD_PC     = 4;
    localparam int CTL_DATACTL_ENA = 5;
    localparam int CTL_ALU_ENA     = 6;
    localparam int CTL_LOAD_ACC    = 7;
    localparam int CTL_HALT        = 8;

    typedef logic [CTL_W-1:0] ctl_vec_t;

    // True for opcodes that read an operand and write the accumulator.
    function automatic logic is_aluop(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (upcoming state, opcode, zero flag) into the
// controller's 9-bit control vector. The result is registered by ctrl_fsm,
// so the vector computed for state Sn is what the outputs show during Sn.
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t           i_next_state,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_zero,
    output ctl_vec_t         o_ctl
);

    // Strobe pattern for each step of the instruction cycle.
    always_comb begin
        o_ctl = '0;
        case (i_next_state)
            S0: begin
                o_ctl[CTL_RD]      = 1'b1;
                o_ctl[CTL_LOAD_IR] = 1'b1;
            end
            S1: begin
                o_ctl[CTL_RD]      = 1'b1;
                o_ctl[CTL_LOAD_IR] = 1'b1;
                o_ctl[CTL_INC_PC]  = 1'b1;
            end
            S3: begin
                o_ctl[CTL_INC_PC] = 1'b1;
                o_ctl[CTL_HALT]   = (i_opcode == OP_HLT);
            end
            S4: begin
                case (i_opcode)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: o_ctl[CTL_RD]          = 1'b1;
                    OP_STO:                         o_ctl[CTL_DATACTL_ENA] = 1'b1;
                    OP_JMP:                         o_ctl[CTL_LOAD_PC]     = 1'b1;
                    OP_SKZ:                         o_ctl[CTL_INC_PC]      = i_zero;
                    default:                        o_ctl                  = '0;
                endcase
            end
            S5: begin
                case (i_opcode)
                    OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                        o_ctl[CTL_RD]      = 1'b1;
                        o_ctl[CTL_ALU_ENA] = 1'b1;
                    end
                    OP_STO: begin
                        o_ctl[CTL_DATACTL_ENA] = 1'b1;
                        o_ctl[CTL_WR]          = 1'b1;
                    end
                    OP_JMP:  o_ctl[CTL_LOAD_PC] = 1'b1;
                    default: o_ctl              = '0;
                endcase
            end
            S6: begin
                if (is_aluop(i_opcode)) begin
                    o_ctl[CTL_RD]       = 1'b1;
                    o_ctl[CTL_LOAD_ACC] = 1'b1;
                end else if (i_opcode == OP_STO) begin
                    o_ctl[CTL_DATACTL_ENA] = 1'b1;
                end else if (i_opcode == OP_SKZ) begin
                    // Second extra increment: together with S4 this skips
                    // one whole 2-byte instruction.
                    o_ctl[CTL_INC_PC] = i_zero;
                end else begin
                    o_ctl = '0;
                end
            end
            HALT:    o_ctl[CTL_HALT] = 1'b1;
            default: o_ctl = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Instruction-cycle controller for the 8-bit RISC core. Steps S0..S7 per
// 2-byte instruction and drives registered fetch/PC/ACC/memory/ALU strobes.
module ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int OPW         = 3,
    parameter int HALT_STICKY = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           load_ir,
    output logic           rd,
    output logic           wr,
    output logic           inc_pc,
    output logic           load_pc,
    output logic           datactl_ena,
    output logic           alu_ena,
    output logic           load_acc,
    output logic           halt,
    output logic [3:0]     state_o
);

    state_t   r_state;
    state_t   w_next_state;
    ctl_vec_t w_ctl;
    ctl_vec_t r_ctl;

    // State register; reset parks the controller in IDLE from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: ena is only looked at in IDLE and S7, so dropping it
    // mid-instruction lets the current instruction finish.
    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: w_next_state = ena ? S0 : IDLE;
            S0:   w_next_state = S1;
            S1:   w_next_state = S2;
            S2:   w_next_state = S3;
            S3: begin
                if ((opcode == OP_HLT) && (HALT_STICKY != 0)) begin
                    w_next_state = HALT;
                end else begin
                    w_next_state = S4;
                end
            end
            S4:      w_next_state = S5;
            S5:      w_next_state = S6;
            S6:      w_next_state = S7;
            S7:      w_next_state = ena ? S0 : IDLE;
            HALT:    w_next_state = HALT;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode is done on the upcoming state so the registered strobes
    // line up with the state they belong to.
    ctrl_decode u_decode (
        .i_next_state (w_next_state),
        .i_opcode     (opcode),
        .i_zero       (zero),
        .o_ctl        (w_ctl)
    );

    // Output register; reset forces every strobe low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctl <= '0;
        end else begin
            r_ctl <= w_ctl;
        end
    end

    assign load_ir     = r_ctl[CTL_LOAD_IR];
    assign rd          = r_ctl[CTL_RD];
    assign wr          = r_ctl[CTL_WR];
    assign inc_pc      = r_ctl[CTL_INC_PC];
    assign load_pc     = r_ctl[CTL_LOAD_PC];
    assign datactl_ena = r_ctl[CTL_DATACTL_ENA];
    assign alu_ena     = r_ctl[CTL_ALU_ENA];
    assign load_acc    = r_ctl[CTL_LOAD_ACC];
    assign halt        = r_ctl[CTL_HALT];
    assign state_o     = r_state;

endmodule
